// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : shares one fixed-latency single-port memory between I and D.
// rev 1.0
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             i_done,
  output logic             d_done,
  output logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] d_rdata,
  output logic             i_stall,
  output logic             d_stall,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             last, last_nxt;      // 0 = I granted last, 1 = D
  logic             op_wr, op_wr_nxt;    // in-flight D op is a write
  logic [WIDTH-1:0] i_hold, i_hold_nxt;
  logic [WIDTH-1:0] d_hold, d_hold_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      last   <= 1'b0;
      op_wr  <= 1'b0;
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last   <= last_nxt;
      op_wr  <= op_wr_nxt;
      i_hold <= i_hold_nxt;
      d_hold <= d_hold_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_nxt   = last;
    op_wr_nxt  = op_wr;
    i_hold_nxt = i_hold;
    d_hold_nxt = d_hold;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    err        = 1'b0;
    i_data     = i_hold;
    d_rdata    = d_hold;

    case (state)
      IDLE: begin
        // On a tie the side that did not win last time is served.
        if (i_req && (!d_req || last)) begin
          mem_en    = 1'b1;
          mem_addr  = i_addr;
          mem_wdata = d_wdata;
          state_nxt = BUSY_I;
          cnt_nxt   = 4'd1;
          last_nxt  = 1'b0;
          op_wr_nxt = 1'b0;
        end else if (d_req) begin
          mem_en    = 1'b1;
          mem_wr    = d_wr;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          state_nxt = BUSY_D;
          cnt_nxt   = 4'd1;
          last_nxt  = 1'b1;
          op_wr_nxt = d_wr;
        end
      end
      BUSY_I: begin
        err = ~i_req;
        if (cnt == LAT) begin
          i_done     = 1'b1;
          i_data     = mem_rdata;
          i_hold_nxt = mem_rdata;
          state_nxt  = IDLE;
          cnt_nxt    = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      BUSY_D: begin
        err = ~d_req;
        if (cnt == LAT) begin
          d_done = 1'b1;
          if (!op_wr) begin
            d_rdata    = mem_rdata;
            d_hold_nxt = mem_rdata;
          end
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase

    // Outputs stay quiet for the whole reset cycle, including any in-flight op.
    if (rst) begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      i_done    = 1'b0;
      d_done    = 1'b0;
      err       = 1'b0;
      i_data    = '0;
      d_rdata   = '0;
    end
  end

  assign i_stall = i_req & ~i_done & ~rst;
  assign d_stall = d_req & ~d_done & ~rst;

endmodule
`default_nettype wire
